// File: rtl/rx_buffer_read_scheduler.sv
// Rx packet ring consumer: reads each committed packet's header, issues bounded DMA
// read chunks, then releases the buffer space through a hold-stable extended read pointer.
module rx_buffer_read_scheduler #(
   parameter int AW       = 9,
   parameter int MAX_QW   = 16,
   parameter int HOLD_CYC = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          enable,
   input  logic [AW:0]   wr_commit_addr,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [63:0]   mem_rd_data,
   output logic          req,
   output logic [AW-1:0] req_addr,
   output logic [7:0]    req_qwords,
   output logic          req_last,
   output logic [31:0]   req_bytes,
   input  logic          req_ack,
   input  logic          chunk_done,
   output logic [AW:0]   rd_addr_extended,
   output logic          rd_addr_change,
   output logic [31:0]   pkt_count,
   output logic          hdr_err,
   output logic          busy
);

   localparam int              AW1        = AW + 1;
   localparam int              TW         = $clog2(2 * HOLD_CYC + 1);
   localparam logic [TW-1:0]   HOLD_T     = TW'(HOLD_CYC);
   localparam logic [TW-1:0]   RELOAD_T   = TW'(2 * HOLD_CYC);
   localparam logic [29:0]     QW_LIMIT   = 30'((1 << AW) - 2);
   localparam logic [AW:0]     RING_WORDS = AW1'(1 << AW);
   localparam logic [7:0]      MAX_LEN    = 8'(MAX_QW);

   typedef enum logic [2:0] {
      IDLE,
      HDR_WAIT,
      REQ,
      DRAIN,
      COMMIT
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [AW:0]     wc_s0;
   logic [AW:0]     wc_s1;
   logic [AW:0]     wc_sync;
   logic [AW:0]     rd_ptr;
   logic [AW:0]     cur;
   logic [AW-1:0]   rem;
   logic [AW:0]     next_ptr;
   logic [31:0]     pkt_bytes;
   logic            pkt_flush;
   logic [AW:0]     outstanding;
   logic [TW-1:0]   hold_timer;

   logic            empty;
   logic [29:0]     hdr_qw;
   logic            hdr_oversize;
   logic            hdr_zero;
   logic [AW:0]     room;
   logic [7:0]      chunk_len;
   logic            chunk_last;
   logic            out_inc;
   logic            out_dec;
   logic            commit_fire;

   assign empty        = (wc_sync == rd_ptr);
   assign hdr_qw       = 30'(({1'b0, mem_rd_data[63:32]} + 33'd7) >> 3);
   assign hdr_oversize = (hdr_qw > QW_LIMIT);
   assign hdr_zero     = (hdr_qw == 30'd0);
   assign out_inc      = (state == REQ) && req_ack;
   assign out_dec      = chunk_done && (outstanding != '0);
   assign commit_fire  = (state == COMMIT) && (hold_timer == '0);

   // Chunk length is the smallest of what is left, the DMA limit and the room before the ring end.
   always_comb begin
      room      = RING_WORDS - {1'b0, cur[AW-1:0]};
      chunk_len = MAX_LEN;
      if (32'(rem) < 32'(chunk_len)) begin
         chunk_len = 8'(rem);
      end
      if (32'(room) < 32'(chunk_len)) begin
         chunk_len = 8'(room);
      end
      chunk_last = (32'(chunk_len) == 32'(rem));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (enable && !empty) begin
               state_next = HDR_WAIT;
            end
         end
         HDR_WAIT: begin
            if (hdr_oversize || hdr_zero) begin
               state_next = COMMIT;
            end else begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (req_ack && chunk_last) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (outstanding == '0) begin
               state_next = COMMIT;
            end
         end
         COMMIT: begin
            if (hold_timer == '0) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_rd_en      = 1'b0;
      mem_rd_addr    = '0;
      req            = 1'b0;
      req_addr       = '0;
      req_qwords     = '0;
      req_last       = 1'b0;
      req_bytes      = '0;
      busy           = (state != IDLE);
      rd_addr_change = (hold_timer > HOLD_T);
      case (state)
         IDLE: begin
            if (enable && !empty) begin
               mem_rd_en   = 1'b1;
               mem_rd_addr = rd_ptr[AW-1:0];
            end
         end
         REQ: begin
            req        = 1'b1;
            req_addr   = cur[AW-1:0];
            req_qwords = chunk_len;
            req_last   = chunk_last;
            req_bytes  = pkt_bytes;
         end
         default: begin
         end
      endcase
   end

   // The commit address crosses clock domains; only a value seen on two consecutive samples is trusted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wc_s0   <= '0;
         wc_s1   <= '0;
         wc_sync <= '0;
      end else begin
         wc_s0 <= wr_commit_addr;
         wc_s1 <= wc_s0;
         if (wc_s1 == wc_s0) begin
            wc_sync <= wc_s1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outstanding <= '0;
      end else if (out_inc && !out_dec) begin
         outstanding <= outstanding + AW1'(1);
      end else if (!out_inc && out_dec) begin
         outstanding <= outstanding - AW1'(1);
      end
   end

   // The released pointer may only move once the previous strobe high/low window has expired.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_timer <= '0;
      end else if (commit_fire) begin
         hold_timer <= RELOAD_T;
      end else if (hold_timer != '0) begin
         hold_timer <= hold_timer - TW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr           <= '0;
         cur              <= '0;
         rem              <= '0;
         next_ptr         <= '0;
         pkt_bytes        <= '0;
         pkt_flush        <= 1'b0;
         rd_addr_extended <= '0;
         pkt_count        <= '0;
         hdr_err          <= 1'b0;
      end else begin
         case (state)
            HDR_WAIT: begin
               pkt_bytes <= mem_rd_data[63:32];
               if (hdr_oversize) begin
                  hdr_err   <= 1'b1;
                  rd_ptr    <= wc_sync;
                  next_ptr  <= wc_sync;
                  pkt_flush <= 1'b1;
               end else if (hdr_zero) begin
                  next_ptr  <= rd_ptr + AW1'(1);
                  pkt_flush <= 1'b0;
               end else begin
                  cur       <= rd_ptr + AW1'(1);
                  rem       <= hdr_qw[AW-1:0];
                  next_ptr  <= rd_ptr + AW1'(1) + hdr_qw[AW:0];
                  pkt_flush <= 1'b0;
               end
            end
            REQ: begin
               if (req_ack) begin
                  cur <= cur + AW1'(chunk_len);
                  rem <= rem - AW'(chunk_len);
               end
            end
            COMMIT: begin
               if (hold_timer == '0) begin
                  rd_addr_extended <= next_ptr;
                  rd_ptr           <= next_ptr;
                  if (!pkt_flush) begin
                     pkt_count <= pkt_count + 32'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_buffer_read_scheduler.sv
// Directed bench for rx_buffer_read_scheduler: a table of packets walked through the ring
// (including wrap and flush), plus back-to-back, enable, sync and mid-request reset sequences.
module tb_rx_buffer_read_scheduler;

   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic [AW:0]   wr_commit_addr;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [63:0]   mem_rd_data;
   logic          req;
   logic [AW-1:0] req_addr;
   logic [7:0]    req_qwords;
   logic          req_last;
   logic [31:0]   req_bytes;
   logic          req_ack;
   logic          chunk_done;
   logic [AW:0]   rd_addr_extended;
   logic          rd_addr_change;
   logic [31:0]   pkt_count;
   logic          hdr_err;
   logic          busy;

   int pass_cnt;
   int total_cnt;

   logic [63:0]   mem [512];
   logic          rd_pend = 1'b0;
   logic [AW-1:0] rd_pend_addr = '0;

   int ch_addr[$];
   int ch_len[$];
   int ch_last[$];
   int ch_bytes[$];
   int upd_ext[$];
   int upd_len[$];
   int upd_cyc[$];

   typedef struct {
      int hdr_addr;
      int bytes;
      int commit;
      int n_chunks;
      int c0_addr;
      int c0_len;
      int c0_last;
      int c1_addr;
      int c1_len;
      int c1_last;
      int exp_ptr;
      int exp_pkts;
      int exp_err;
   } row_t;

   row_t rows[5];

   rx_buffer_read_scheduler #(.AW(AW), .MAX_QW(16), .HOLD_CYC(4)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .enable           (enable),
      .wr_commit_addr   (wr_commit_addr),
      .mem_rd_en        (mem_rd_en),
      .mem_rd_addr      (mem_rd_addr),
      .mem_rd_data      (mem_rd_data),
      .req              (req),
      .req_addr         (req_addr),
      .req_qwords       (req_qwords),
      .req_last         (req_last),
      .req_bytes        (req_bytes),
      .req_ack          (req_ack),
      .chunk_done       (chunk_done),
      .rd_addr_extended (rd_addr_extended),
      .rd_addr_change   (rd_addr_change),
      .pkt_count        (pkt_count),
      .hdr_err          (hdr_err),
      .busy             (busy)
   );

   always #2 clk = ~clk;

   // Buffer model: data appears only in the cycle after the read strobe, junk otherwise.
   always @(negedge clk) begin
      if (rd_pend) begin
         mem_rd_data = mem[rd_pend_addr];
      end else begin
         mem_rd_data = 64'hDEAD_0BAD_DEAD_0BAD;
      end
      rd_pend      = mem_rd_en;
      rd_pend_addr = mem_rd_addr;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total_cnt++;
      if (actual == expected) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input row_t r);
      mem[r.hdr_addr % 512] = {32'(r.bytes), 32'hA5A5_0000 | 32'(r.hdr_addr)};
      wr_commit_addr = 10'(r.commit);
   endtask

   // Acts as the DMA engine: accepts every request at once, reports it done one cycle later,
   // and logs chunks and pointer updates until n_upd strobe windows have completed.
   task automatic service(input int max_cycles, input int n_upd);
      int hi = 0;
      bit pend = 1'b0;
      ch_addr.delete(); ch_len.delete(); ch_last.delete(); ch_bytes.delete();
      upd_ext.delete(); upd_len.delete(); upd_cyc.delete();
      for (int c = 0; c < max_cycles && upd_len.size() < n_upd; c++) begin
         @(negedge clk);
         req_ack    = 1'b0;
         chunk_done = pend;
         pend       = 1'b0;
         if (req) begin
            ch_addr.push_back(int'(req_addr));
            ch_len.push_back(int'(req_qwords));
            ch_last.push_back(int'(req_last));
            ch_bytes.push_back(int'(req_bytes));
            req_ack = 1'b1;
            pend    = 1'b1;
         end
         if (rd_addr_change) begin
            if (hi == 0) begin
               upd_ext.push_back(int'(rd_addr_extended));
               upd_cyc.push_back(c);
            end
            hi++;
         end else if (hi != 0) begin
            upd_len.push_back(hi);
            hi = 0;
         end
      end
      req_ack    = 1'b0;
      chunk_done = 1'b0;
      checkOutput("updates_seen", upd_len.size(), n_upd);
   endtask

   initial begin
      int bad;
      int got;
      int gap;
      logic tog;

      pass_cnt       = 0;
      total_cnt      = 0;
      reset_n        = 1'b0;
      enable         = 1'b0;
      wr_commit_addr = '0;
      req_ack        = 1'b0;
      chunk_done     = 1'b0;
      for (int i = 0; i < 512; i++) mem[i] = 64'd0;

      //          hdr  bytes commit n  c0a  c0l l  c1a c1l l  ptr  pkts err
      rows[0] = '{0,   64,   9,     1, 1,   8,  1, 0,  0,  0, 9,   1,   0};
      rows[1] = '{9,   200,  35,    2, 10,  16, 0, 26, 9,  1, 35,  2,   0};
      rows[2] = '{35,  5000, 505,   0, 0,   0,  0, 0,  0,  0, 505, 2,   1};
      rows[3] = '{505, 80,   516,   2, 506, 6,  0, 0,  4,  1, 516, 3,   1};
      rows[4] = '{4,   0,    517,   0, 0,   0,  0, 0,  0,  0, 517, 4,   1};

      repeat (3) @(negedge clk);
      checkOutput("rst_mem_rd_en", int'(mem_rd_en), 0);
      checkOutput("rst_req", int'(req), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_ext", int'(rd_addr_extended), 0);
      checkOutput("rst_change", int'(rd_addr_change), 0);
      checkOutput("rst_pkt_count", int'(pkt_count), 0);
      checkOutput("rst_hdr_err", int'(hdr_err), 0);

      reset_n = 1'b1;
      enable  = 1'b1;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (mem_rd_en || busy || req) bad++;
      end
      checkOutput("empty_stays_idle", bad, 0);

      enable = 1'b0;
      chunk_done = 1'b1;
      @(negedge clk);
      chunk_done = 1'b0;

      for (int r = 0; r < 5; r++) begin
         applyStimulus(rows[r]);
         if (r == 0) begin
            bad = 0;
            for (int c = 0; c < 15; c++) begin
               @(negedge clk);
               if (mem_rd_en || busy) bad++;
            end
            checkOutput("disabled_no_start", bad, 0);
            enable = 1'b1;
         end
         service(400, 1);
         checkOutput($sformatf("row%0d_n_chunks", r), ch_addr.size(), rows[r].n_chunks);
         for (int i = 0; i < ch_addr.size() && i < 2; i++) begin
            checkOutput($sformatf("row%0d_c%0d_addr", r, i), ch_addr[i],
                        (i == 0) ? rows[r].c0_addr : rows[r].c1_addr);
            checkOutput($sformatf("row%0d_c%0d_len", r, i), ch_len[i],
                        (i == 0) ? rows[r].c0_len : rows[r].c1_len);
            checkOutput($sformatf("row%0d_c%0d_last", r, i), ch_last[i],
                        (i == 0) ? rows[r].c0_last : rows[r].c1_last);
            checkOutput($sformatf("row%0d_c%0d_bytes", r, i), ch_bytes[i], rows[r].bytes);
         end
         if (upd_ext.size() > 0) begin
            checkOutput($sformatf("row%0d_ext", r), upd_ext[0], rows[r].exp_ptr);
         end
         if (upd_len.size() > 0) begin
            checkOutput($sformatf("row%0d_change_len", r), upd_len[0], 4);
         end
         checkOutput($sformatf("row%0d_pkt_count", r), int'(pkt_count), rows[r].exp_pkts);
         checkOutput($sformatf("row%0d_hdr_err", r), int'(hdr_err), rows[r].exp_err);
         checkOutput($sformatf("row%0d_ext_hold", r), int'(rd_addr_extended), rows[r].exp_ptr);
      end

      // Two single-qword packets committed together: the second release must wait out the hold window.
      mem[5] = {32'd8, 32'h0000_0005};
      mem[7] = {32'd8, 32'h0000_0007};
      wr_commit_addr = 10'd521;
      service(400, 2);
      checkOutput("b2b_n_chunks", ch_addr.size(), 2);
      if (ch_addr.size() == 2) begin
         checkOutput("b2b_c0_addr", ch_addr[0], 6);
         checkOutput("b2b_c1_addr", ch_addr[1], 8);
         checkOutput("b2b_c1_len", ch_len[1], 1);
      end
      if (upd_ext.size() == 2) begin
         checkOutput("b2b_ext0", upd_ext[0], 519);
         checkOutput("b2b_ext1", upd_ext[1], 521);
         gap = upd_cyc[1] - upd_cyc[0];
         checkOutput("b2b_gap_ge_8", int'(gap >= 8), 1);
      end
      checkOutput("b2b_pkt_count", int'(pkt_count), 6);

      mem[9] = {32'd64, 32'h0000_0009};
      wr_commit_addr = 10'd530;
      got = 0;
      for (int c = 0; c < 40 && got == 0; c++) begin
         @(negedge clk);
         got = int'(req);
      end
      checkOutput("midreq_req_seen", got, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("midreq_rst_req", int'(req), 0);
      checkOutput("midreq_rst_busy", int'(busy), 0);
      checkOutput("midreq_rst_ext", int'(rd_addr_extended), 0);
      checkOutput("midreq_rst_pkt_count", int'(pkt_count), 0);
      checkOutput("midreq_rst_hdr_err", int'(hdr_err), 0);

      tog = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tog = ~tog;
         wr_commit_addr = {{AW{1'b0}}, tog};
      end
      reset_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         tog = ~tog;
         wr_commit_addr = {{AW{1'b0}}, tog};
         if (mem_rd_en || busy) bad++;
      end
      checkOutput("toggle_never_syncs", bad, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/rx_buffer_read_scheduler.md
Name: rx_buffer_read_scheduler

Overview:
Consumer-side controller for the Ethernet Rx packet ring buffer in the 250 MHz PCIe domain. It tracks committed packets from the MAC-side writer, reads each packet's header word, and splits the payload into bounded DMA read requests for the host transfer engine. After a packet is fully transferred it releases the buffer space by publishing an updated extended read pointer with a hold-stable change strobe.

Parameters:
AW, 9, buffer word-address width (ring depth 2^AW 64-bit words)
MAX_QW, 16, maximum qwords per DMA request (1..255)
HOLD_CYC, 4, cycles rd_addr_change is held high, then held low, per pointer update

Ports:
clk  in  1  250 MHz clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  allow new packets to be started
wr_commit_addr  in  AW+1  writer's committed extended address (foreign clock domain)
mem_rd_en  out  1  buffer read strobe
mem_rd_addr  out  AW  buffer read address
mem_rd_data  in  64  read data, valid exactly 1 cycle after mem_rd_en
req  out  1  DMA request valid
req_addr  out  AW  first buffer word of chunk
req_qwords  out  8  chunk length in qwords
req_last  out  1  chunk is the packet's final chunk
req_bytes  out  32  packet byte count (valid with req)
req_ack  in  1  request accepted
chunk_done  in  1  one-cycle pulse, oldest accepted chunk transferred
rd_addr_extended  out  AW+1  released read pointer
rd_addr_change  out  1  pointer-update strobe
pkt_count  out  32  packets released
hdr_err  out  1  sticky oversize-header flag
busy  out  1  state != IDLE

Behaviour:
- Reset (async): all outputs 0; rd_ptr, wc_sync, counters, timers 0; state IDLE.
- Commit sync: wr_commit_addr double-registered (s0, s1); wc_sync <= s1 only when s1 == s0 (stable two consecutive samples). Otherwise wc_sync holds.
- Empty: wc_sync == rd_ptr (full AW+1 compare). All pointer arithmetic mod 2^(AW+1); memory address = low AW bits.
- States:
  - IDLE: if enable && !empty: mem_rd_en=1, mem_rd_addr=rd_ptr[AW-1:0] for one cycle -> HDR_WAIT.
  - HDR_WAIT: capture bytes=mem_rd_data[63:32]; qw=(bytes+7)>>3 (33-bit add, no overflow).
    - qw > 2^AW-2 -> hdr_err<=1, rd_ptr<=wc_sync, go COMMIT (flush).
    - qw == 0 -> next_ptr=rd_ptr+1, go COMMIT.
    - Else cur=rd_ptr+1, rem=qw, go REQ.
  - REQ: req=1, req_addr=cur[AW-1:0], req_qwords=min(rem, MAX_QW, 2^AW-cur[AW-1:0]) (no chunk crosses buffer end), req_last=(req_qwords==rem). All req_* stable until req_ack. On ack: cur+=len, rem-=len, outstanding++ ; if rem==0 -> DRAIN else stay REQ (next request earliest cycle after ack).
  - DRAIN: each chunk_done decrements outstanding (also counted in REQ). outstanding==0 -> COMMIT.
  - COMMIT: wait until hold timer == 0; then rd_addr_extended<=next_ptr (packet end = rd_ptr+1+qw, or flush target), rd_ptr<=same, pkt_count++ (not for flush), timer<=2*HOLD_CYC -> IDLE.
- Hold timer: rd_addr_change=1 while timer > HOLD_CYC, 0 otherwise; decrements to 0. rd_addr_extended never changes while timer != 0. Next header read may start during timer.
- chunk_done with outstanding==0: ignored. Simultaneous req_ack and chunk_done: both applied (net outstanding unchanged).
- enable deassert: current packet completes; no new header read.
- Latency: non-empty detect to mem_rd_en 1 cycle; header to req 2 cycles.

Test Plan:
- Reset, AW=9: wr_commit_addr=0 -> no mem_rd_en, all outputs 0, busy=0.
- Header at 0 bytes=64, wr_commit_addr=9: one req addr=1 qwords=8 last=1; after ack+done, rd_addr_extended=9, rd_addr_change high 4 cycles, pkt_count=1.
- bytes=200 (25 qw) at rd_ptr=0: requests 16@1, 9@17, last on second; released pointer 26.
- Wrap: rd_ptr=505, bytes=80 (10 qw): chunks 6@506, 4@0; rd_addr_extended=516 (bit AW set).
- bytes=0: no req, pointer+1; bytes=5000 (625 qw): hdr_err=1, rd_addr_extended=wc_sync, pkt_count unchanged.
- Back-to-back two 8-byte packets: second pointer update not before 8 cycles after first; wr_commit_addr toggling each cycle never updates wc_sync; reset_n low mid-REQ clears req and state.
